alarm_clock_controller: RTL and testbench
=========================================

Name: alarm_clock_controller

Overview:
Central sequencer for the alarm clock's up/down modulo counters. It generates the enable, load and direction controls for the seconds, minutes and hours time counters and for the alarm minutes and hours counters. It runs the mode state machine for setting time and alarm, cascades carries from the 1 Hz tick, and detects and times the alarm ring. It sits between the debounced button/tick logic and the counter bank; the display reads `mode` and `ring`.

Parameters:
SEC_MOD, 60, seconds modulus (carry when sec_count == SEC_MOD-1)
MIN_MOD, 60, minutes modulus
HR_MOD, 24, hours modulus
RING_SECS, 60, ticks the alarm rings before auto-silence (1..63)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
tick  in  1  1 Hz single-cycle pulse; consecutive pulses at least 2 cycles apart
btn_mode  in  1  debounced single-cycle pulse: advance mode
btn_up  in  1  debounced pulse: increment selected field
btn_down  in  1  debounced pulse: decrement selected field
btn_center  in  1  debounced pulse: toggle alarm enable / silence ring
sec_count  in  6  current seconds counter value
min_count  in  6  current minutes counter value
hr_count  in  5  current hours counter value
alm_min_count  in  6  alarm minutes value
alm_hr_count  in  5  alarm hours value
sec_en, min_en, hr_en  out  1 each  time-counter enables
sec_ld  out  1  seconds load strobe (counter `in` tied to 0 externally)
alm_min_en, alm_hr_en  out  1 each  alarm-counter enables
up_down  out  1  shared direction: 0 = up, 1 = down
mode  out  3  0=RUN 1=SET_HR 2=SET_MIN 3=ALM_HR 4=ALM_MIN
alm_on  out  1  alarm armed by user
ring  out  1  alarm sounding

Behaviour:
- All outputs are registered. Every enable and load is a one-cycle pulse, asserted in the cycle after the causing input.
- Reset (rst=0 at a clk edge): mode=RUN; all enables and sec_ld low; up_down=0; alm_on=0; ring=0; ring counter=0; match_armed=1. Reset mid-ring or mid-edit takes effect immediately.
- Mode FSM: each btn_mode pulse advances RUN->SET_HR->SET_MIN->ALM_HR->ALM_MIN->RUN. No other transitions.
- RUN, tick pulse:
  - sec_en=1, up_down=0.
  - If sec_count==SEC_MOD-1, also min_en=1.
  - If additionally min_count==MIN_MOD-1, also hr_en=1.
  - All enables are in the same cycle. Carries are decided from the counts sampled in the tick cycle.
- RUN, btn_center (not ringing): toggle alm_on. btn_up and btn_down are ignored in RUN.
- Set states: tick is ignored, so the clock is paused.
  - btn_up pulses the selected field's enable with up_down=0.
  - btn_down pulses it with up_down=1.
  - Field selection: SET_HR->hr_en, SET_MIN->min_en, ALM_HR->alm_hr_en, ALM_MIN->alm_min_en.
  - btn_up and btn_down in the same cycle: ignored, no pulse.
  - Wrap-around is handled by the counters, e.g. down at 0 gives MOD-1.
- Leaving SET_MIN (btn_mode in SET_MIN): sec_en=1 and sec_ld=1 for one cycle, so seconds reset to 0.
- Simultaneous btn_mode with btn_up or btn_down: the mode change wins and the field press is dropped.
- Alarm match = (mode==RUN) & alm_on & hr_count==alm_hr_count & min_count==alm_min_count & sec_count==0.
  - If match & match_armed & !ring: ring<=1, match_armed<=0, ring counter<=0.
  - match_armed<=1 whenever match is false.
  - This prevents re-trigger within the same second after a silence.
- While ring=1:
  - Each tick increments the ring counter; ring clears when the counter reaches RING_SECS.
  - Any button pulse (mode/up/down/center) clears ring and is consumed: no mode change, alm_on toggle or field edit in that cycle.
  - Timekeeping continues normally.
- alm_on cleared by any means also clears ring.
- Tick and a button in the same cycle in RUN: both are acted on (the tick cascade plus the center toggle).

Test Plan:
1. Reset with all inputs 0 -> mode=0, all outputs 0; the first tick yields sec_en=1 only, one cycle later.
2. sec=59, min=59, hr=23, tick -> sec_en, min_en and hr_en all 1 in the same single cycle, up_down=0. With sec=59, min=10, tick -> sec_en and min_en only.
3. btn_mode ×1, btn_down ×2 -> two hr_en pulses with up_down=1, clock paused across ticks. btn_mode again, then btn_up -> min_en pulse. btn_mode -> one cycle with sec_en=1 and sec_ld=1, mode=3.
4. btn_up and btn_down in the same cycle in SET_MIN -> no enables. btn_mode together with btn_up in SET_HR -> mode=2, no hr_en.
5. alm_on=1, alarm 07:30, time reaches 07:30:00 -> ring=1 the next cycle. btn_center -> ring=0 and alm_on stays 1, with no re-ring while sec remains 0. Reaching the match again 24 h later (forced counts) -> ring again.
6. Ring left alone -> ring drops after exactly RING_SECS=60 ticks. Ringing, then rst=0 -> ring=0, alm_on=0, mode=0 at the next edge.

Source files
------------

// File: rtl/alarm_clock_controller_if.sv
// Alarm clock controller bundle: buttons, tick and counter values in; counter controls and status out.
// Latency: none (wires only).
// Backpressure: none; every strobe is a single-cycle pulse.
//   master: button/tick logic plus counter bank side (drives pulses and counts, reads controls)
//   slave : alarm_clock_controller (reads pulses and counts, drives controls, mode, alm_on and ring)
interface alarm_clock_controller_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_center;
  logic [5:0] sec_count;
  logic [5:0] min_count;
  logic [4:0] hr_count;
  logic [5:0] alm_min_count;
  logic [4:0] alm_hr_count;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       sec_ld;
  logic       alm_min_en;
  logic       alm_hr_en;
  logic       up_down;
  logic [2:0] mode;
  logic       alm_on;
  logic       ring;

  modport master (
    output tick, btn_mode, btn_up, btn_down, btn_center,
    output sec_count, min_count, hr_count, alm_min_count, alm_hr_count,
    input  sec_en, min_en, hr_en, sec_ld, alm_min_en, alm_hr_en, up_down,
    input  mode, alm_on, ring
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, btn_center,
    input  sec_count, min_count, hr_count, alm_min_count, alm_hr_count,
    output sec_en, min_en, hr_en, sec_ld, alm_min_en, alm_hr_en, up_down,
    output mode, alm_on, ring
  );
endinterface

// File: rtl/alarm_clock_controller.sv
// Alarm clock sequencer: mode FSM, tick carry cascade, field edits and alarm ring timing.
// Latency: every output is registered; pulses appear one cycle after the causing input.
// Backpressure: none; inputs are single-cycle pulses and are acted on (or dropped) immediately.
//   Ports: clk, rst (sync, active-low), bus (slave side of alarm_clock_controller_if).
module alarm_clock_controller #(
  parameter int SEC_MOD   = 60,
  parameter int MIN_MOD   = 60,
  parameter int HR_MOD    = 24,
  parameter int RING_SECS = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  alarm_clock_controller_if.slave   bus
);

  localparam logic [2:0] M_RUN     = 3'd0;
  localparam logic [2:0] M_SET_HR  = 3'd1;
  localparam logic [2:0] M_SET_MIN = 3'd2;
  localparam logic [2:0] M_ALM_HR  = 3'd3;
  localparam logic [2:0] M_ALM_MIN = 3'd4;

  localparam logic [5:0] SEC_LAST  = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_LAST  = 6'(MIN_MOD - 1);
  localparam logic [6:0] RING_LAST = 7'(RING_SECS);

  logic [2:0] mode_q, mode_d;
  logic       sec_en_q, sec_en_d;
  logic       min_en_q, min_en_d;
  logic       hr_en_q, hr_en_d;
  logic       sec_ld_q, sec_ld_d;
  logic       alm_min_en_q, alm_min_en_d;
  logic       alm_hr_en_q, alm_hr_en_d;
  logic       up_down_q, up_down_d;
  logic       alm_on_q, alm_on_d;
  logic       ring_q, ring_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic       armed_q, armed_d;

  logic any_btn;
  logic mode_adv;
  logic edit;
  logic match;

  // While ringing, any button only silences; nothing else reacts to it.
  assign any_btn  = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_center;
  assign mode_adv = bus.btn_mode & ~ring_q;
  // A mode press beats a simultaneous field press; up+down together cancel.
  assign edit     = ~ring_q & ~bus.btn_mode & (bus.btn_up ^ bus.btn_down);

  assign match = (mode_q == M_RUN) && alm_on_q
              && (bus.hr_count == bus.alm_hr_count)
              && (bus.min_count == bus.alm_min_count)
              && (bus.sec_count == 6'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= M_RUN;
      sec_en_q     <= 1'b0;
      min_en_q     <= 1'b0;
      hr_en_q      <= 1'b0;
      sec_ld_q     <= 1'b0;
      alm_min_en_q <= 1'b0;
      alm_hr_en_q  <= 1'b0;
      up_down_q    <= 1'b0;
      alm_on_q     <= 1'b0;
      ring_q       <= 1'b0;
      ring_cnt_q   <= 6'd0;
      armed_q      <= 1'b1;
    end else begin
      mode_q       <= mode_d;
      sec_en_q     <= sec_en_d;
      min_en_q     <= min_en_d;
      hr_en_q      <= hr_en_d;
      sec_ld_q     <= sec_ld_d;
      alm_min_en_q <= alm_min_en_d;
      alm_hr_en_q  <= alm_hr_en_d;
      up_down_q    <= up_down_d;
      alm_on_q     <= alm_on_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      armed_q      <= armed_d;
    end
  end

  // Next-state: strict cycle through the five modes
  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      case (mode_q)
        M_RUN:     mode_d = M_SET_HR;
        M_SET_HR:  mode_d = M_SET_MIN;
        M_SET_MIN: mode_d = M_ALM_HR;
        M_ALM_HR:  mode_d = M_ALM_MIN;
        default:   mode_d = M_RUN;
      endcase
    end
  end

  // Outputs: counter strobes, alarm enable and ring timer
  always_comb begin
    sec_en_d     = 1'b0;
    min_en_d     = 1'b0;
    hr_en_d      = 1'b0;
    sec_ld_d     = 1'b0;
    alm_min_en_d = 1'b0;
    alm_hr_en_d  = 1'b0;
    up_down_d    = 1'b0;
    alm_on_d     = alm_on_q;
    ring_d       = ring_q;
    ring_cnt_d   = ring_cnt_q;
    armed_d      = armed_q;

    case (mode_q)
      M_RUN: begin
        // Carries use the counts seen in the tick cycle, all strobes together.
        if (bus.tick) begin
          sec_en_d = 1'b1;
          if (bus.sec_count == SEC_LAST) begin
            min_en_d = 1'b1;
            if (bus.min_count == MIN_LAST) hr_en_d = 1'b1;
          end
        end
        if (bus.btn_center && !ring_q) alm_on_d = ~alm_on_q;
      end
      M_SET_HR: begin
        hr_en_d   = edit;
        up_down_d = edit & bus.btn_down;
      end
      M_SET_MIN: begin
        min_en_d  = edit;
        up_down_d = edit & bus.btn_down;
        // Leaving minute edit zeroes the seconds via a load.
        if (mode_adv) begin
          sec_en_d = 1'b1;
          sec_ld_d = 1'b1;
        end
      end
      M_ALM_HR: begin
        alm_hr_en_d = edit;
        up_down_d   = edit & bus.btn_down;
      end
      M_ALM_MIN: begin
        alm_min_en_d = edit;
        up_down_d    = edit & bus.btn_down;
      end
      default: ;
    endcase

    if (ring_q) begin
      if (any_btn) begin
        ring_d = 1'b0;
      end else if (bus.tick) begin
        ring_cnt_d = ring_cnt_q + 6'd1;
        if (({1'b0, ring_cnt_q} + 7'd1) == RING_LAST) ring_d = 1'b0;
      end
    end else if (match && armed_q) begin
      ring_d     = 1'b1;
      armed_d    = 1'b0;
      ring_cnt_d = 6'd0;
    end

    // Re-arm only once the match condition has gone away, so a silence
    // inside the matching second cannot immediately re-trigger.
    if (!match) armed_d = 1'b1;
    if (!alm_on_d) ring_d = 1'b0;
  end

  assign bus.sec_en     = sec_en_q;
  assign bus.min_en     = min_en_q;
  assign bus.hr_en      = hr_en_q;
  assign bus.sec_ld     = sec_ld_q;
  assign bus.alm_min_en = alm_min_en_q;
  assign bus.alm_hr_en  = alm_hr_en_q;
  assign bus.up_down    = up_down_q;
  assign bus.mode       = mode_q;
  assign bus.alm_on     = alm_on_q;
  assign bus.ring       = ring_q;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Bench for alarm_clock_controller: directed stimulus with a cycle-stamped pulse scoreboard.
// Pulse vector order: {sec_en, min_en, hr_en, sec_ld, alm_hr_en, alm_min_en, up_down}.
// Status outputs (mode, alm_on, ring) are checked directly from the stimulus thread.
module tb_alarm_clock_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alarm_clock_controller_if ifc ();

  alarm_clock_controller #(
    .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24), .RING_SECS(60)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [6:0]  v;
  } ev_t;

  ev_t         exq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = 0;
  logic [6:0]  mon_vec;
  ev_t         mon_e;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Monitor: every cycle with a strobe must match the oldest expected pulse.
  always @(negedge clk) begin
    mon_vec = {ifc.sec_en, ifc.min_en, ifc.hr_en, ifc.sec_ld,
               ifc.alm_hr_en, ifc.alm_min_en, ifc.up_down};
    if ((ifc.sec_en | ifc.min_en | ifc.hr_en | ifc.sec_ld |
         ifc.alm_hr_en | ifc.alm_min_en) === 1'b1) begin
      tests++;
      if (exq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, mon_vec);
      end else begin
        mon_e = exq.pop_front();
        if (mon_e.v !== mon_vec || mon_e.cyc !== cyc) begin
          fails++;
          $display("FAIL pulse got=%b@%0d required=%b@%0d", mon_vec, cyc, mon_e.v, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [6:0] v);
    exq.push_back({cyc + 32'd1, v});
  endtask

  // One clock: inputs set before this call are sampled at the posedge; return at negedge.
  task automatic go();
    @(posedge clk);
    @(negedge clk);
    ifc.tick       = 1'b0;
    ifc.btn_mode   = 1'b0;
    ifc.btn_up     = 1'b0;
    ifc.btn_down   = 1'b0;
    ifc.btn_center = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    ifc.hr_count  = h;
    ifc.min_count = m;
    ifc.sec_count = s;
  endtask

  initial begin
    ifc.tick = 0; ifc.btn_mode = 0; ifc.btn_up = 0; ifc.btn_down = 0; ifc.btn_center = 0;
    ifc.alm_hr_count = 5'd7; ifc.alm_min_count = 6'd30;
    set_time(5'd0, 6'd0, 6'd0);
    @(negedge clk);
    go(); go();

    // 1. reset state
    chk("rst_mode", {5'b0, ifc.mode}, 8'd0);
    chk("rst_alm_on", {7'b0, ifc.alm_on}, 8'd0);
    chk("rst_ring", {7'b0, ifc.ring}, 8'd0);
    chk("rst_strobes", {1'b0, ifc.sec_en, ifc.min_en, ifc.hr_en, ifc.sec_ld,
                        ifc.alm_hr_en, ifc.alm_min_en, ifc.up_down}, 8'd0);
    rst = 1'b1;
    go();
    ifc.tick = 1'b1; expect_ev(7'b1000000); go(); go();

    // 2. carry cascade
    set_time(5'd23, 6'd59, 6'd59);
    ifc.tick = 1'b1; expect_ev(7'b1110000); go(); go();
    set_time(5'd23, 6'd10, 6'd59);
    ifc.tick = 1'b1; expect_ev(7'b1100000); go(); go();
    set_time(5'd23, 6'd10, 6'd10);
    ifc.tick = 1'b1; expect_ev(7'b1000000); go(); go();

    // 3. edit hours, minutes; clock paused
    ifc.btn_mode = 1'b1; go();
    chk("mode_set_hr", {5'b0, ifc.mode}, 8'd1);
    ifc.btn_down = 1'b1; expect_ev(7'b0010001); go();
    ifc.tick = 1'b1; go();
    ifc.btn_down = 1'b1; expect_ev(7'b0010001); go();
    ifc.tick = 1'b1; go();
    ifc.btn_mode = 1'b1; go();
    chk("mode_set_min", {5'b0, ifc.mode}, 8'd2);
    ifc.btn_up = 1'b1; expect_ev(7'b0100000); go();
    ifc.tick = 1'b1; go();

    // 4. up+down cancel; leaving SET_MIN loads seconds
    ifc.btn_up = 1'b1; ifc.btn_down = 1'b1; go(); go();
    ifc.btn_mode = 1'b1; expect_ev(7'b1001000); go();
    chk("mode_alm_hr", {5'b0, ifc.mode}, 8'd3);
    ifc.btn_up = 1'b1; expect_ev(7'b0000100); go();
    ifc.btn_mode = 1'b1; go();
    chk("mode_alm_min", {5'b0, ifc.mode}, 8'd4);
    ifc.btn_down = 1'b1; expect_ev(7'b0000011); go();
    ifc.btn_mode = 1'b1; go();
    chk("mode_wrap_run", {5'b0, ifc.mode}, 8'd0);
    ifc.btn_mode = 1'b1; go();
    ifc.btn_mode = 1'b1; ifc.btn_up = 1'b1; go();
    chk("mode_beats_up", {5'b0, ifc.mode}, 8'd2);
    ifc.btn_mode = 1'b1; expect_ev(7'b1001000); go();
    ifc.btn_mode = 1'b1; go();
    ifc.btn_mode = 1'b1; go();
    chk("mode_back_run", {5'b0, ifc.mode}, 8'd0);

    // 5. alarm match, silence, no re-ring in same second, re-ring later
    ifc.btn_center = 1'b1; go();
    chk("alm_on_set", {7'b0, ifc.alm_on}, 8'd1);
    set_time(5'd7, 6'd29, 6'd59);
    ifc.tick = 1'b1; expect_ev(7'b1100000); go();
    chk("no_ring_early", {7'b0, ifc.ring}, 8'd0);
    set_time(5'd7, 6'd30, 6'd0);
    go();
    chk("ring_on_match", {7'b0, ifc.ring}, 8'd1);
    ifc.btn_center = 1'b1; go();
    chk("ring_silenced", {7'b0, ifc.ring}, 8'd0);
    chk("alm_on_kept", {7'b0, ifc.alm_on}, 8'd1);
    go(); go(); go();
    chk("no_rering", {7'b0, ifc.ring}, 8'd0);
    set_time(5'd7, 6'd30, 6'd5); go();
    set_time(5'd7, 6'd30, 6'd0); go();
    chk("ring_again", {7'b0, ifc.ring}, 8'd1);
    ifc.btn_mode = 1'b1; go();
    chk("ring_mode_consumed", {5'b0, ifc.mode}, 8'd0);
    chk("ring_mode_silenced", {7'b0, ifc.ring}, 8'd0);

    // 6. auto-silence after 60 ticks
    set_time(5'd7, 6'd30, 6'd5); go();
    set_time(5'd7, 6'd30, 6'd0); go();
    chk("ring_third", {7'b0, ifc.ring}, 8'd1);
    set_time(5'd7, 6'd30, 6'd1);
    for (int i = 0; i < 59; i++) begin
      ifc.tick = 1'b1; expect_ev(7'b1000000); go(); go();
    end
    chk("ring_tick59", {7'b0, ifc.ring}, 8'd1);
    ifc.tick = 1'b1; expect_ev(7'b1000000); go();
    chk("ring_tick60", {7'b0, ifc.ring}, 8'd0);

    // Reset while ringing
    set_time(5'd7, 6'd30, 6'd0); go();
    chk("ring_before_rst", {7'b0, ifc.ring}, 8'd1);
    rst = 1'b0; go();
    chk("rst_ring_clr", {7'b0, ifc.ring}, 8'd0);
    chk("rst_alm_clr", {7'b0, ifc.alm_on}, 8'd0);
    chk("rst_mode_clr", {5'b0, ifc.mode}, 8'd0);

    // Reset mid-edit
    rst = 1'b1; go();
    ifc.btn_mode = 1'b1; go();
    chk("edit_mode", {5'b0, ifc.mode}, 8'd1);
    rst = 1'b0; go();
    chk("edit_rst_mode", {5'b0, ifc.mode}, 8'd0);
    rst = 1'b1; go();

    // Tick and center together in RUN
    set_time(5'd7, 6'd30, 6'd3);
    ifc.tick = 1'b1; ifc.btn_center = 1'b1; expect_ev(7'b1000000); go();
    chk("tick_center_alm", {7'b0, ifc.alm_on}, 8'd1);
    go(); go();

    chk("queue_drained", 8'(exq.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
